// File: rtl/multicycle_itype_core.sv
// Multicycle I-type core: FETCH/DECODE/EXEC/WB/HALT over a small register file.
// Optional macro ITYPE_CORE_OVF_TRAP_EN turns signed ADDI overflow into a halt trap.
module multicycle_itype_core #(
    parameter int DATA_W    = 32,
    parameter int NREG_LOG2 = 5,
    parameter int PC_W      = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_valid,
    input  logic [31:0]       imem_data,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic [PC_W-1:0]   pc,
    output logic              halted,
    output logic              illegal,
    output logic [2:0]        o_dbg_state
);

    localparam int NREG = 1 << NREG_LOG2;

    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [31:0]         r_ir;
    logic [DATA_W-1:0]   r_rf [NREG];
    logic [DATA_W-1:0]   r_rs_val;
    logic [DATA_W-1:0]   r_rt_val;
    logic [DATA_W-1:0]   r_imm_s;
    logic [DATA_W-1:0]   r_imm_z;
    logic [DATA_W-1:0]   r_result;
    logic                r_result_valid;
    logic                r_imem_req;
    logic                r_halted;
    logic                r_illegal;

    logic [5:0]           w_opcode;
    logic [NREG_LOG2-1:0] w_rs_idx;
    logic [NREG_LOG2-1:0] w_rt_idx;
    logic [DATA_W-1:0]    w_imm_sext;
    logic [DATA_W-1:0]    w_imm_zext;
    logic [PC_W-1:0]      w_pc_plus4;
    logic [PC_W-1:0]      w_br_off;
    logic                 w_br_taken;
    logic [DATA_W-1:0]    w_add;
    logic [DATA_W-1:0]    w_alu;

    assign w_opcode   = r_ir[31:26];
    assign w_rs_idx   = r_ir[21 +: NREG_LOG2];
    assign w_rt_idx   = r_ir[16 +: NREG_LOG2];
    assign w_imm_sext = DATA_W'($signed(r_ir[15:0]));
    assign w_imm_zext = DATA_W'(r_ir[15:0]);
    assign w_pc_plus4 = r_pc + PC_W'(4);
    // Word offset shifted into a byte offset before sign extension to PC_W.
    assign w_br_off   = PC_W'($signed({r_ir[15:0], 2'b00}));
    assign w_br_taken = (w_opcode == OP_BEQ) ? (r_rs_val == r_rt_val)
                                             : (r_rs_val != r_rt_val);
    assign w_add      = r_rs_val + r_imm_s;

`ifdef ITYPE_CORE_OVF_TRAP_EN
    logic w_ovf;
    assign w_ovf = (r_rs_val[DATA_W-1] == r_imm_s[DATA_W-1]) &&
                   (w_add[DATA_W-1] != r_rs_val[DATA_W-1]);
`endif

    always_comb begin
        w_alu = '0;
        case (w_opcode)
            OP_ADDI: w_alu = w_add;
            OP_SLTI: w_alu = DATA_W'($signed(r_rs_val) < $signed(r_imm_s));
            OP_ANDI: w_alu = r_rs_val & r_imm_z;
            OP_ORI:  w_alu = r_rs_val | r_imm_z;
            default: w_alu = '0;
        endcase
    end

    // Fetch handshake: imem_req is held until an edge sees imem_valid=1 with
    // imem_req=1; that edge captures imem_data and drops the request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_FETCH;
            r_pc           <= '0;
            r_ir           <= '0;
            r_rs_val       <= '0;
            r_rt_val       <= '0;
            r_imm_s        <= '0;
            r_imm_z        <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_imem_req     <= 1'b0;
            r_halted       <= 1'b0;
            r_illegal      <= 1'b0;
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (!r_imem_req) begin
                        r_imem_req <= 1'b1;
                    end else if (imem_valid) begin
                        r_ir       <= imem_data;
                        r_imem_req <= 1'b0;
                        r_state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_rs_val <= r_rf[w_rs_idx];
                    r_rt_val <= r_rf[w_rt_idx];
                    r_imm_s  <= w_imm_sext;
                    r_imm_z  <= w_imm_zext;
                    r_state  <= S_EXEC;
                end
                S_EXEC: begin
                    case (w_opcode)
                        OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
                            r_result <= w_alu;
`ifdef ITYPE_CORE_OVF_TRAP_EN
                            if ((w_opcode == OP_ADDI) && w_ovf) begin
                                r_halted <= 1'b1;
                                r_state  <= S_HALT;
                            end else begin
                                r_result_valid <= 1'b1;
                                r_state        <= S_WB;
                            end
`else
                            r_result_valid <= 1'b1;
                            r_state        <= S_WB;
`endif
                        end
                        OP_BEQ, OP_BNE: begin
                            r_pc       <= w_br_taken ? (w_pc_plus4 + w_br_off) : w_pc_plus4;
                            r_imem_req <= 1'b1;
                            r_state    <= S_FETCH;
                        end
                        OP_HALT: begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end
                        default: begin
                            r_illegal  <= 1'b1;
                            r_pc       <= w_pc_plus4;
                            r_imem_req <= 1'b1;
                            r_state    <= S_FETCH;
                        end
                    endcase
                end
                S_WB: begin
                    // Register 0 is hardwired: it is never written, so it always reads zero.
                    if (w_rt_idx != '0) r_rf[w_rt_idx] <= r_result;
                    r_pc       <= w_pc_plus4;
                    r_imem_req <= 1'b1;
                    r_state    <= S_FETCH;
                end
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign imem_req     = r_imem_req;
    assign imem_addr    = r_pc;
    assign pc           = r_pc;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign halted       = r_halted;
    assign illegal      = r_illegal;
    assign o_dbg_state  = r_state;

endmodule
